// File: rtl/pipe_control_if.sv
// Handshake bundle between the pipeline sequencer and its neighbours.
//   slave  : sequencer side (takes hazard/jmp/memory flags, drives controls)
//   master : environment side (drives the flags, observes the controls)
// Signals:
//   hazard, jmp, mem_req, mem_ack       : status flags into the sequencer
//   f_en, d_en, e_en                     : per-stage advance enables
//   d_bubble, e_bubble, flush            : invalidate / squash controls
//   busy, stall_count[CNT_W], deadlock   : status out of the sequencer
interface pipe_control_if #(
    parameter int CNT_W = 16
);
    logic             hazard;
    logic             jmp;
    logic             mem_req;
    logic             mem_ack;
    logic             f_en;
    logic             d_en;
    logic             e_en;
    logic             d_bubble;
    logic             e_bubble;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] stall_count;
    logic             deadlock;

    modport master (
        output hazard, jmp, mem_req, mem_ack,
        input  f_en, d_en, e_en, d_bubble, e_bubble, flush, busy,
               stall_count, deadlock
    );

    modport slave (
        input  hazard, jmp, mem_req, mem_ack,
        output f_en, d_en, e_en, d_bubble, e_bubble, flush, busy,
               stall_count, deadlock
    );
endinterface

// File: rtl/pipe_control.sv
// Stall/flush sequencer for a 3-stage (fetch/decode/execute) pipeline.
// Combines the hazard detector, taken jumps and the data-memory handshake
// into per-stage advance enables and bubble/flush controls. Control outputs
// are decoded combinationally from the state and the current inputs; state,
// counters and the sticky deadlock flag are registered.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset (all outputs read 0 while low)
//   pif  : pipe_control_if.slave bundle (flags in, controls/status out)
module pipe_control #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 64,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipe_control_if.slave  pif
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int HC_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_t;

    state_t           state_q,    state_d;
    logic [FC_W-1:0]  cnt_q,      cnt_d;
    logic [HC_W-1:0]  hcnt_q,     hcnt_d;
    logic [CNT_W-1:0] stall_q,    stall_d;
    logic             deadlock_q, deadlock_d;

    logic f_en_c, d_en_c, e_en_c, d_bub_c, e_bub_c, flush_c;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hcnt_d     = '0;
        deadlock_d = deadlock_q;
        f_en_c     = 1'b0;
        d_en_c     = 1'b0;
        e_en_c     = 1'b0;
        d_bub_c    = 1'b0;
        e_bub_c    = 1'b0;
        flush_c    = 1'b0;

        case (state_q)
            RUN: begin
                if (pif.jmp) begin
                    f_en_c  = 1'b1;
                    d_en_c  = 1'b1;
                    e_en_c  = 1'b1;
                    d_bub_c = 1'b1;
                    e_bub_c = 1'b1;
                    flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (pif.mem_req && !pif.mem_ack) begin
                    state_d = MEMWAIT;
                end else if (pif.mem_req && pif.mem_ack) begin
                    f_en_c = 1'b1;
                    d_en_c = 1'b1;
                    e_en_c = 1'b1;
                end else if (pif.hazard) begin
                    // Hold fetch/decode, let execute drain with a bubble.
                    e_en_c  = 1'b1;
                    e_bub_c = 1'b1;
                    // hcnt holds at MAX_STALL-1 so it cannot wrap.
                    hcnt_d  = (hcnt_q == HC_W'(MAX_STALL - 1)) ? hcnt_q
                                                                : hcnt_q + HC_W'(1);
                    if (hcnt_q == HC_W'(MAX_STALL - 1)) begin
                        deadlock_d = 1'b1;
                    end
                end else begin
                    f_en_c = 1'b1;
                    d_en_c = 1'b1;
                    e_en_c = 1'b1;
                end
            end

            FLUSH: begin
                // Decode holds squashed contents, so hazard is not consulted.
                f_en_c  = 1'b1;
                d_en_c  = 1'b1;
                e_en_c  = 1'b1;
                d_bub_c = 1'b1;
                e_bub_c = 1'b1;
                if (pif.jmp) begin
                    flush_c = 1'b1;
                    cnt_d   = FC_W'(FLUSH_CYCLES - 1);
                end else if (cnt_q == FC_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - FC_W'(1);
                end
            end

            MEMWAIT: begin
                // Execute is frozen; only the memory acknowledge matters.
                if (pif.mem_ack) begin
                    f_en_c  = 1'b1;
                    d_en_c  = 1'b1;
                    e_en_c  = 1'b1;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        stall_d = (!f_en_c && (stall_q != {CNT_W{1'b1}})) ? stall_q + CNT_W'(1)
                                                           : stall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            stall_q    <= '0;
            deadlock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            stall_q    <= stall_d;
            deadlock_q <= deadlock_d;
        end
    end

    // Decoded controls are gated so that nothing advances while reset is low.
    assign pif.f_en        = rst & f_en_c;
    assign pif.d_en        = rst & d_en_c;
    assign pif.e_en        = rst & e_en_c;
    assign pif.d_bubble    = rst & d_bub_c;
    assign pif.e_bubble    = rst & e_bub_c;
    assign pif.flush       = rst & flush_c;
    assign pif.busy        = rst & (state_q != RUN);
    assign pif.stall_count = stall_q;
    assign pif.deadlock    = deadlock_q;
endmodule
